// File: rtl/sram_stream_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sram_stream_master
//  Description : Burst master for a shared single-port SRAM. Read bursts
//                stream SRAM words out through a small return FIFO over
//                valid/ready; write bursts accept a valid/ready stream and
//                store it at consecutive addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_stream_master #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic                  sram_oe
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W:0]        FIFO_LIMIT = (CNT_W+1)'(FIFO_DEPTH - 1);

  logic [1:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  xfer_q, xfer_d;      // reads issued / writes accepted
  logic [LEN_WIDTH-1:0]  popped_q, popped_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;      // next address to present
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic                  sram_cs_q, sram_cs_d;
  logic                  sram_we_q, sram_we_d;
  logic                  sram_oe_q, sram_oe_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_p1_q, rd_p1_d;    // read presented this cycle
  logic                  rd_p2_q, rd_p2_d;    // read data on the bus this cycle
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  cmd_fire;
  logic                  wr_fire;
  logic                  push;
  logic                  pop;
  logic [CNT_W:0]        in_flight;
  logic                  rd_issue;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign wr_fire   = wr_valid & wr_ready;
  assign push      = rd_p2_q;
  assign pop       = rd_valid & rd_ready;
  // Buffered words plus reads whose data has not yet been captured; a new
  // read is only issued when a FIFO slot is guaranteed for its return.
  assign in_flight = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_p1_q} + {{CNT_W{1'b0}}, rd_p2_q};
  assign rd_issue  = (state_q == S_RD) && (xfer_q < len_q) && (in_flight <= FIFO_LIMIT);

  assign rd_valid  = (count_q != '0);
  assign rd_data   = fifo_mem_q[rptr_q];
  assign sram_addr = sram_addr_q;
  assign sram_cs   = sram_cs_q;
  assign sram_we   = sram_we_q;
  assign sram_oe   = sram_oe_q;
  assign sram_data = sram_we_q ? wdata_q : {DATA_WIDTH{1'bz}};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_fire) begin
        if (cmd_len == '0)  state_d = S_FIN;
        else if (cmd_write) state_d = S_WR;
        else                state_d = S_RD;
      end
      S_RD:   if (pop && (popped_q + LEN_ONE == len_q)) state_d = S_FIN;
      S_WR:   if (xfer_q == len_q) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
    wr_ready  = (state_q == S_WR) && (xfer_q < len_q);
  end

  // Datapath: command latch, address generation, SRAM strobes, return FIFO
  always_comb begin
    len_d       = len_q;
    xfer_d      = xfer_q;
    popped_d    = popped_q;
    addr_d      = addr_q;
    sram_addr_d = sram_addr_q;
    sram_cs_d   = 1'b0;
    sram_we_d   = 1'b0;
    sram_oe_d   = 1'b0;
    wdata_d     = wdata_q;
    rd_p1_d     = 1'b0;
    rd_p2_d     = rd_p1_q;
    fifo_mem_d  = fifo_mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;

    if ((state_q == S_IDLE) && cmd_fire) begin
      len_d    = cmd_len;
      xfer_d   = '0;
      popped_d = '0;
      addr_d   = cmd_addr;
      // The first read is issued straight from the command cycle so the
      // base address is already on the bus in the first RD cycle.
      if (!cmd_write && (cmd_len != '0)) begin
        sram_addr_d = cmd_addr;
        addr_d      = cmd_addr + ADDR_ONE;
        xfer_d      = LEN_ONE;
        sram_cs_d   = 1'b1;
        sram_oe_d   = 1'b1;
        rd_p1_d     = 1'b1;
      end
    end

    if (rd_issue) begin
      sram_addr_d = addr_q;
      addr_d      = addr_q + ADDR_ONE;
      xfer_d      = xfer_q + LEN_ONE;
      sram_cs_d   = 1'b1;
      sram_oe_d   = 1'b1;
      rd_p1_d     = 1'b1;
    end

    // Keep the SRAM selected and driving while a return is due next cycle.
    if ((state_q == S_RD) && rd_p1_q) begin
      sram_cs_d = 1'b1;
      sram_oe_d = 1'b1;
    end

    if (wr_fire) begin
      sram_addr_d = addr_q;
      addr_d      = addr_q + ADDR_ONE;
      xfer_d      = xfer_q + LEN_ONE;
      sram_cs_d   = 1'b1;
      sram_we_d   = 1'b1;
      wdata_d     = wr_data;
    end

    if (push) begin
      fifo_mem_d[wptr_q] = sram_data;
      wptr_d             = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d   = rptr_q + PTR_ONE;
      popped_d = popped_q + LEN_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Datapath registers; reset aborts any burst and discards buffered data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q       <= '0;
      xfer_q      <= '0;
      popped_q    <= '0;
      addr_q      <= '0;
      sram_addr_q <= '0;
      sram_cs_q   <= 1'b0;
      sram_we_q   <= 1'b0;
      sram_oe_q   <= 1'b0;
      wdata_q     <= '0;
      rd_p1_q     <= 1'b0;
      rd_p2_q     <= 1'b0;
      fifo_mem_q  <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      len_q       <= len_d;
      xfer_q      <= xfer_d;
      popped_q    <= popped_d;
      addr_q      <= addr_d;
      sram_addr_q <= sram_addr_d;
      sram_cs_q   <= sram_cs_d;
      sram_we_q   <= sram_we_d;
      sram_oe_q   <= sram_oe_d;
      wdata_q     <= wdata_d;
      rd_p1_q     <= rd_p1_d;
      rd_p2_q     <= rd_p2_d;
      fifo_mem_q  <= fifo_mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_stream_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sram_stream_master
//  Description : Directed bench for sram_stream_master with a behavioural
//                single-port SRAM attached to the bidirectional data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_stream_master;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;
  logic          sram_cs;
  logic          sram_we;
  logic          sram_oe;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_stream_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .done(done),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_oe(sram_oe)
  );

  // Behavioural SRAM: read data appears the cycle after the address,
  // writes store at the edge ending the presentation cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] sram_rdata_q;
  logic          sram_drv_q;

  always @(posedge clk) begin
    sram_drv_q <= sram_cs && !sram_we && sram_oe;
    if (sram_cs && !sram_we && sram_oe) sram_rdata_q <= mem[sram_addr];
    if (sram_cs && sram_we) mem[sram_addr] <= sram_data;
  end

  assign sram_data = (sram_drv_q && sram_oe && !sram_we) ? sram_rdata_q : {DW{1'bz}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer a command in cycle 0; returns in cycle 1 of the burst.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_rd_valid"},  rd_valid,  0);
    chk({tag, "_wr_ready"},  wr_ready,  0);
    chk({tag, "_cs"},        sram_cs,   0);
    chk({tag, "_we"},        sram_we,   0);
    chk({tag, "_oe"},        sram_oe,   0);
    chk({tag, "_addr"},      sram_addr, 0);
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [DW-1:0] base);
    int n = 0;
    int cyc = 0;
    wr_valid = 1'b1;
    wr_data  = base;
    send_cmd(1'b1, a, l);
    while (!done && cyc < 200) begin
      wr_data = base + DW'(n);
      if (wr_ready) n++;
      tick();
      cyc++;
    end
    wr_valid = 1'b0;
    chk("wrb_done", done, 1);
    chk("wrb_count", n, 32'(l));
    tick();
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [DW-1:0] base, input string tag);
    int n = 0;
    int cyc = 0;
    rd_ready = 1'b1;
    send_cmd(1'b0, a, l);
    while (!done && cyc < 200) begin
      if (rd_valid) begin
        chk($sformatf("%s_data%0d", tag, n), rd_data, base + DW'(n));
        n++;
      end
      tick();
      cyc++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_count"}, n, 32'(l));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [AW-1:0] wrap_addr [3];
    logic [6:0]    vp;
    int            k;
    int            widx;
    int            wcnt;
    int            n;
    int            cyc;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // ---------------- write len=4 at 0x010 ----------------
    wr_valid = 1'b1;
    wr_data  = 16'hA001;
    send_cmd(1'b1, 10'h010, 11'd4);
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("wr1_ready_c%0d", c), wr_ready, (c <= 4));
      chk($sformatf("wr1_we_c%0d", c), sram_we, (c >= 2 && c <= 5));
      chk($sformatf("wr1_done_c%0d", c), done, (c == 6));
      if (c >= 2 && c <= 5) begin
        chk($sformatf("wr1_addr_c%0d", c), sram_addr, 10'h010 + c - 2);
        chk($sformatf("wr1_data_c%0d", c), sram_data, 16'hA001 + DW'(c - 2));
        chk($sformatf("wr1_cs_c%0d", c), sram_cs, 1);
        chk($sformatf("wr1_oe_c%0d", c), sram_oe, 0);
      end
      wr_data = 16'hA000 + DW'(c);
      tick();
    end
    wr_valid = 1'b0;
    chk("wr1_idle_cmd_ready", cmd_ready, 1);
    chk("wr1_idle_busy", busy, 0);

    // ---------------- read len=4 at 0x010 ----------------
    rd_ready = 1'b1;
    send_cmd(1'b0, 10'h010, 11'd4);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("rd1_valid_c%0d", c), rd_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6)
        chk($sformatf("rd1_data_c%0d", c), rd_data, 16'hA001 + DW'(c - 3));
      chk($sformatf("rd1_done_c%0d", c), done, (c == 7));
      chk($sformatf("rd1_we_c%0d", c), sram_we, 0);
      if (c <= 4) begin
        chk($sformatf("rd1_cs_c%0d", c), sram_cs, 1);
        chk($sformatf("rd1_oe_c%0d", c), sram_oe, 1);
        chk($sformatf("rd1_addr_c%0d", c), sram_addr, 10'h010 + c - 1);
      end
      tick();
    end
    chk("rd1_idle", cmd_ready, 1);

    // ---------------- preload through the master ----------------
    write_burst(10'h100, 11'd16, 16'hB000);
    write_burst(10'h3FE, 11'd3, 16'hC001);
    chk("wrap_wr_mem0", mem[0], 16'hC003);

    // ---------------- backpressure: read len=8, rd_ready low 6 cycles ----
    rd_ready = 1'b0;
    send_cmd(1'b0, 10'h100, 11'd8);
    for (int c = 1; c <= 6; c++) begin
      if (c >= 3) begin
        chk($sformatf("bp_valid_c%0d", c), rd_valid, 1);
        chk($sformatf("bp_stable_c%0d", c), rd_data, 16'hB000);
      end
      chk($sformatf("bp_we_c%0d", c), sram_we, 0);
      if (c == 6) begin
        chk("bp_issue_stopped_cs", sram_cs, 0);
        chk("bp_last_issued_addr", sram_addr, 10'h103);
      end
      tick();
    end
    rd_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 8 && cyc < 60) begin
      if (rd_valid) begin
        chk($sformatf("bp_data%0d", n), rd_data, 16'hB000 + DW'(n));
        n++;
      end
      tick();
      cyc++;
    end
    chk("bp_count", n, 8);
    cyc = 0;
    while (!done && cyc < 5) begin
      tick();
      cyc++;
    end
    chk("bp_done", done, 1);
    tick();

    // ---------------- wrap: read len=3 at 0x3FE ----------------
    wrap_addr[0] = 10'h3FE;
    wrap_addr[1] = 10'h3FF;
    wrap_addr[2] = 10'h000;
    rd_ready = 1'b1;
    send_cmd(1'b0, 10'h3FE, 11'd3);
    for (int c = 1; c <= 6; c++) begin
      if (c <= 3) begin
        chk($sformatf("wrap_cs_c%0d", c), sram_cs, 1);
        chk($sformatf("wrap_addr_c%0d", c), sram_addr, wrap_addr[c-1]);
      end
      chk($sformatf("wrap_valid_c%0d", c), rd_valid, (c >= 3 && c <= 5));
      if (c >= 3 && c <= 5)
        chk($sformatf("wrap_data_c%0d", c), rd_data, 16'hC001 + DW'(c - 3));
      chk($sformatf("wrap_done_c%0d", c), done, (c == 6));
      tick();
    end

    // ---------------- zero length ----------------
    send_cmd(1'b0, 10'h055, 11'd0);
    chk("zl_done_c1", done, 1);
    chk("zl_busy_c1", busy, 1);
    chk("zl_cmd_ready_c1", cmd_ready, 0);
    chk("zl_cs_c1", sram_cs, 0);
    tick();
    chk("zl_done_c2", done, 0);
    chk("zl_cmd_ready_c2", cmd_ready, 1);
    chk("zl_cs_c2", sram_cs, 0);
    chk("zl_busy_c2", busy, 0);

    // ---------------- write stream with gaps ----------------
    vp = 7'b0011010;  // wr_valid per cycle 1..6
    k = 0;
    widx = 0;
    wcnt = 0;
    wr_valid = 1'b0;
    send_cmd(1'b1, 10'h200, 11'd3);
    for (int c = 1; c <= 6; c++) begin
      wr_valid = vp[c];
      wr_data  = 16'hD001 + DW'(k);
      chk($sformatf("gap_we_c%0d", c), sram_we, (c == 2 || c == 4 || c == 5));
      if (sram_we) wcnt++;
      if (c == 2 || c == 4 || c == 5) begin
        chk($sformatf("gap_addr_c%0d", c), sram_addr, 10'h200 + widx);
        chk($sformatf("gap_data_c%0d", c), sram_data, 16'hD001 + DW'(widx));
        widx++;
      end
      chk($sformatf("gap_done_c%0d", c), done, (c == 6));
      if (wr_valid && wr_ready) k++;
      tick();
    end
    wr_valid = 1'b0;
    chk("gap_write_cycles", wcnt, 3);
    chk("gap_mem0", mem[10'h200], 16'hD001);
    chk("gap_mem1", mem[10'h201], 16'hD002);
    chk("gap_mem2", mem[10'h202], 16'hD003);

    // ---------------- reset in cycle 4 of a len=16 read ----------------
    rd_ready = 1'b1;
    send_cmd(1'b0, 10'h100, 11'd16);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("midrst_nodone%0d", c), done, 0);
      chk($sformatf("midrst_idle%0d", c), busy, 0);
      tick();
    end
    read_burst(10'h010, 11'd4, 16'hA001, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_stream_master.md
Name: sram_stream_master

Overview:
- Bus-initiator counterpart of the shared single-port SRAM (addr, bidirectional data, cs, we, oe).
- Accepts a burst command (base, length, direction).
- Read bursts: fetches words from SRAM and streams them out over valid/ready.
- Write bursts: accepts a valid/ready stream and writes it to consecutive SRAM addresses.
- Sits between the accelerator datapath/loader and external SRAM, as the only SRAM driver.

Parameters:
- ADDR_WIDTH, 10, SRAM address bits; depth 2**ADDR_WIDTH
- DATA_WIDTH, 16, word width; equals SRAM DATA_WIDTH
- LEN_WIDTH, ADDR_WIDTH+1, burst length field width; allows a full-memory burst
- FIFO_DEPTH, 4, read-return buffer entries (fixed 4; power of two)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_WIDTH  burst base address
- cmd_len  in  LEN_WIDTH  word count; 0 = no-op
- rd_data  out  DATA_WIDTH  read stream word (FIFO head)
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  consumer accepts
- wr_data  in  DATA_WIDTH  write stream word
- wr_valid  in  1  producer offers
- wr_ready  out  1  master accepts
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst completion
- sram_addr  out  ADDR_WIDTH  registered
- sram_data  inout  DATA_WIDTH  driven only while sram_we=1, else high-Z
- sram_cs  out  1  registered chip select
- sram_we  out  1  registered write enable
- sram_oe  out  1  registered output enable

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; counters and FIFO cleared; cmd_ready=1.
  - busy, done, rd_valid, wr_ready, sram_cs, sram_we, sram_oe all 0; sram_addr=0; sram_data high-Z.
  - Reset mid-burst aborts immediately: no done pulse, buffered data discarded.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - Handshake cmd_valid&cmd_ready latches cmd_addr, cmd_len, cmd_write.
  - cmd_len=0 -> FIN; else cmd_write ? WR : RD.
  - Command fields are ignored at all other times.
- Address generation: the address increments by 1 per issued word and wraps 2**ADDR_WIDTH-1 -> 0.
- SRAM timing: the SRAM samples addr/cs/we at a rising edge.
  - Read data appears on sram_data the cycle after addr is presented with cs=1, we=0, oe=1.
  - Write stores sram_data at the edge ending the cycle it is presented with cs=1, we=1.
- RD:
  - Read-issue condition: words_issued < len and fifo_count + outstanding <= FIFO_DEPTH-1. Outstanding = reads presented last cycle, not yet captured.
  - Sustains 1 word/cycle with rd_ready=1.
  - sram_oe=1 and sram_cs=1 are held every cycle a read is presented or a return is pending.
  - sram_we=0 throughout RD.
  - Data is captured from sram_data at the end of the cycle after presentation and pushed to the FIFO.
  - FIFO pops on rd_valid&rd_ready.
  - Latency: command accepted cycle 0 -> first addr presented cycle 1 -> rd_valid=1 cycle 3.
  - Exit: all len words popped -> FIN.
- WR:
  - wr_ready=1 while words_accepted < len.
  - Handshake in cycle k: cycle k+1 presents addr, cs=1, we=1, oe=0, and drives sram_data=registered word.
  - No handshake in cycle k: cycle k+1 has cs=0, we=0.
  - Exit: after the cycle presenting the last word -> FIN.
  - No bubbles are inserted; throughput is 1 word/cycle.
- FIN: done=1 for one cycle, busy=1, cmd_ready=0. Next cycle IDLE.
- Bus rules:
  - Controller never drives sram_data while sram_we=0.
  - Read and write never overlap, because IDLE/FIN separate bursts.
  - cs=0 whenever idle.
- Simultaneous FIFO push and pop keep the count unchanged.
- rd_data is stable while rd_valid=1 and rd_ready=0.

Test Plan:
- Write then read: write len=4 at 0x010 with data 0xA001..0xA004, wr_valid held high.
  - Expect wr_ready cycles 1-4.
  - Expect we=1 with addr 0x010..0x013 in cycles 2-5, done in cycle 6.
  - Then a read len=4 at 0x010 with rd_ready=1: rd_valid in cycles 3-6 of that burst with data 0xA001..0xA004, done in cycle 7.
- Backpressure:
  - Read len=8 with rd_ready low for 6 cycles: issue stops at 4 buffered words.
  - No data lost; output order 0..7 intact; rd_data stable while stalled.
- Wrap: read len=3 at 0x3FE -> addresses 0x3FE, 0x3FF, 0x000; three words in order.
- Zero length: cmd_len=0 -> no sram_cs, done pulse cycle 1, cmd_ready=1 cycle 2.
- Write stream gaps: wr_valid toggling 1,0,1,1 for len=3 -> exactly three write cycles, each one cycle after its handshake; sram_data high-Z otherwise.
- Reset mid-read: rst_n=0 in cycle 4 of a len=16 read -> next cycle all outputs at reset values, no done; a subsequent command works normally.
